// File: rtl/ps2_key_receiver_pkg.sv
// PS/2 receiver shared types and constants: FSM state encoding, scan-code prefixes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  localparam logic [PS2_DATA_BITS-1:0] PS2_BREAK = 8'hF0;
  localparam logic [PS2_DATA_BITS-1:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // PS/2 uses odd parity: the data bits together with the parity bit
  // must contain an odd number of ones.
  function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic                     par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Bundle of PS/2 pins plus the decoded key outputs seen by the processor.
// Latency: n/a (wires only).
// Backpressure: none; the consumer samples on the one-cycle pulses.
// Ports: ps2_clk/ps2_data (pins into receiver), ps2_out/ps2_key_pressed/frame_err (receiver out).
interface ps2_key_receiver_if;
  import ps2_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic [PS2_DATA_BITS-1:0] ps2_out;
  logic                     ps2_key_pressed;
  logic                     frame_err;

  // Receiver side
  modport master (
    input  ps2_clk,
    input  ps2_data,
    output ps2_out,
    output ps2_key_pressed,
    output frame_err
  );

  // Board pins / processor side
  modport slave (
    output ps2_clk,
    output ps2_data,
    input  ps2_out,
    input  ps2_key_pressed,
    input  frame_err
  );

endinterface

// File: rtl/ps2_key_receiver_sync.sv
// Two-flop synchroniser for the PS/2 clock/data pins plus a registered falling-edge tick.
// Latency: pin fall -> fall_tick high 3 clock cycles later; data_sync is aligned with fall_tick.
// Backpressure: none; fall_tick is a single-cycle pulse.
// Ports: clock, reset (sync, active-low), ps2_clk/ps2_data pins in, data_sync/fall_tick out.
module sync_fall_detect (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_tick
);

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;

  // Everything resets to 1 (the idle level of the bus) so that releasing
  // reset never fabricates a falling edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_prev  <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
      data_sync <= 1'b1;
      fall_tick <= 1'b0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      clk_prev  <= clk_s2;
      data_s1   <= ps2_data;
      data_s2   <= data_s1;
      // Registered so the tick and the sampled data leave this block together;
      // PS/2 data is stable for half a bit period around the clock fall.
      fall_tick <= clk_prev & ~clk_s2;
      data_sync <= data_s2;
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: deserialise, parity/stop check, break/extended filter, stall timeout.
// Latency: outputs update 4 clock cycles after the stop-bit falling edge at the pin.
// Backpressure: none; ps2_key_pressed and frame_err are one-cycle pulses the consumer must catch.
// Ports: clock, reset (sync, active-low), bus (ps2_key_receiver_if.master: pins in, key/err out).
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int BREAK_FILTER   = 1
) (
  input  logic                clock,
  input  logic                reset,
  ps2_key_receiver_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BIT_W = $clog2(PS2_DATA_BITS);

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(PS2_DATA_BITS - 1);

  logic data_sync;
  logic fall_tick;

  ps2_state_t               state;
  logic [BIT_W-1:0]         bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift_reg;
  logic                     parity_bit;
  logic [CNT_W-1:0]         idle_cnt;
  logic                     break_pending;
  logic [PS2_DATA_BITS-1:0] out_q;
  logic                     key_pressed_q;
  logic                     frame_err_q;

  sync_fall_detect u_sync (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .data_sync (data_sync),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      idle_cnt      <= '0;
      break_pending <= 1'b0;
      out_q         <= '0;
      key_pressed_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      key_pressed_q <= 1'b0;
      frame_err_q   <= 1'b0;

      // Stall detector: only runs mid-frame, saturates rather than wrapping.
      if (state == IDLE || fall_tick) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TIMEOUT_VAL) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      if (fall_tick) begin
        case (state)
          IDLE: begin
            // A high "start bit" is a glitch or mis-sync; stay put.
            if (!data_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_sync, shift_reg[PS2_DATA_BITS-1:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            parity_bit <= data_sync;
            state      <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (data_sync && ps2_parity_ok(shift_reg, parity_bit)) begin
              if (BREAK_FILTER != 0) begin
                // F0 arms suppression of the released key's code; E0 is a
                // prefix only and must not disturb a pending break.
                if (shift_reg == PS2_BREAK) begin
                  break_pending <= 1'b1;
                end else if (shift_reg == PS2_EXT) begin
                  break_pending <= break_pending;
                end else if (break_pending) begin
                  break_pending <= 1'b0;
                end else begin
                  out_q         <= shift_reg;
                  key_pressed_q <= 1'b1;
                end
              end else begin
                out_q         <= shift_reg;
                key_pressed_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && idle_cnt == TIMEOUT_VAL) begin
        // Abandon the stalled frame; break_pending survives so a release
        // sequence split by a stall is still honoured.
        state       <= IDLE;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.ps2_out         = out_q;
  assign bus.ps2_key_pressed = key_pressed_q;
  assign bus.frame_err       = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench: two receivers (break filter on/off) share the same PS/2 pin stimulus.
module tb_ps2_key_receiver;
  import ps2_pkg::*;

  localparam int HALF = 20;  // PS/2 half-period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #10 clock = ~clock;

  ps2_key_receiver_if bus1 ();
  ps2_key_receiver_if bus2 ();

  assign bus1.ps2_clk  = ps2_clk;
  assign bus1.ps2_data = ps2_data;
  assign bus2.ps2_clk  = ps2_clk;
  assign bus2.ps2_data = ps2_data;

  ps2_key_receiver #(.TIMEOUT_CYCLES(5000), .BREAK_FILTER(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.master)
  );

  ps2_key_receiver #(.TIMEOUT_CYCLES(5000), .BREAK_FILTER(0)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2.master)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int key_cyc = 0;
  int key_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int key2_cnt = 0;
  logic [7:0] key2_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus1.ps2_key_pressed) begin
      key_cnt++;
      key_cyc = cyc;
    end
    if (bus1.frame_err) err_cnt++;
    if (bus1.ps2_key_pressed && bus1.frame_err) both_cnt++;
    if (bus2.ps2_key_pressed) begin
      key2_cnt++;
      key2_q.push_back(bus2.ps2_out);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(stp);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  int k0, e0, k20;
  logic [7:0] q;

  initial begin
    wait_cyc(5);
    // Reset state
    check_eq("reset_out", {24'd0, bus1.ps2_out}, 32'h00);
    check_eq("reset_key", {31'd0, bus1.ps2_key_pressed}, 32'd0);
    check_eq("reset_err", {31'd0, bus1.frame_err}, 32'd0);
    reset = 1'b1;
    wait_cyc(5);

    // Make code 0x1C, parity 0 (three ones in the byte)
    k0 = key_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_eq("make_cnt", key_cnt - k0, 1);
    check_eq("make_out", {24'd0, bus1.ps2_out}, 32'h1C);
    check_eq("make_lat", key_cyc - fall_cyc, 4);
    check_eq("make_err", err_cnt - e0, 0);

    // Break sequence F0 1C 32
    k0 = key_cnt; k20 = key2_cnt; key2_q.delete();
    send_good(8'hF0);
    send_good(8'h1C);
    check_eq("brk_suppr", key_cnt - k0, 0);
    send_good(8'h32);
    check_eq("brk_cnt", key_cnt - k0, 1);
    check_eq("brk_out", {24'd0, bus1.ps2_out}, 32'h32);
    check_eq("nof_cnt", key2_cnt - k20, 3);
    q = (key2_q.size() > 0) ? key2_q[0] : 8'h00;
    check_eq("nof_0", {24'd0, q}, 32'hF0);
    q = (key2_q.size() > 1) ? key2_q[1] : 8'h00;
    check_eq("nof_1", {24'd0, q}, 32'h1C);
    q = (key2_q.size() > 2) ? key2_q[2] : 8'h00;
    check_eq("nof_2", {24'd0, q}, 32'h32);

    // Extended prefix E0 75 -> only 75 delivered
    k0 = key_cnt;
    send_good(8'hE0);
    send_good(8'h75);
    check_eq("ext_cnt", key_cnt - k0, 1);
    check_eq("ext_out", {24'd0, bus1.ps2_out}, 32'h75);

    // Parity error, then good 1B
    k0 = key_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check_eq("par_err", err_cnt - e0, 1);
    check_eq("par_key", key_cnt - k0, 0);
    check_eq("par_hold", {24'd0, bus1.ps2_out}, 32'h75);
    send_good(8'h1B);
    check_eq("par_next", {24'd0, bus1.ps2_out}, 32'h1B);

    // Stop-bit error
    k0 = key_cnt; e0 = err_cnt;
    send_frame(8'h29, ~^8'h29, 1'b0);
    check_eq("stop_err", err_cnt - e0, 1);
    check_eq("stop_key", key_cnt - k0, 0);

    // Glitch: falling edge with data high while idle
    e0 = err_cnt; k0 = key_cnt;
    send_bit(1'b1);
    wait_cyc(HALF);
    check_eq("glitch_err", err_cnt - e0, 0);
    check_eq("glitch_key", key_cnt - k0, 0);
    send_good(8'h29);
    check_eq("glitch_next", {24'd0, bus1.ps2_out}, 32'h29);

    // Timeout: start + 3 data bits then stall
    k0 = key_cnt; e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 6000 && err_cnt == e0; i++) wait_cyc(1);
    check_eq("tmo_err", err_cnt - e0, 1);
    check_eq("tmo_key", key_cnt - k0, 0);
    e0 = err_cnt;
    send_good(8'h2A);
    check_eq("tmo_next", {24'd0, bus1.ps2_out}, 32'h2A);
    check_eq("tmo_next_err", err_cnt - e0, 0);

    // Reset mid-frame after 5 data bits
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    reset = 1'b0;
    wait_cyc(1);
    reset = 1'b1;
    wait_cyc(1);
    check_eq("rst_out", {24'd0, bus1.ps2_out}, 32'h00);
    check_eq("rst_key", {31'd0, bus1.ps2_key_pressed}, 32'd0);
    check_eq("rst_err", {31'd0, bus1.frame_err}, 32'd0);
    e0 = err_cnt; k0 = key_cnt;
    wait_cyc(HALF);
    send_good(8'h45);
    check_eq("rst_next", {24'd0, bus1.ps2_out}, 32'h45);
    check_eq("rst_next_cnt", key_cnt - k0, 1);
    check_eq("rst_next_err", err_cnt - e0, 0);

    check_eq("no_overlap", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
